ysyx_23060072_multdiv: RTL and testbench
========================================

# ysyx_23060072_multdiv

Iterative RV32 M-extension unit in the EX stage: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.

- Drives the hold request that the pipeline controller ORs into the EX/ID/IF hold chain.
- Produces a write-back result after a fixed 33-cycle latency.
- Honors the controller's clean (flush) and global EX hold in return.

## Interface
Parameters:
- XLEN, 32, operand/result width
- RD_W, 4, destination register address width (RV32E)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- req_i  in  1  EX holds a valid M-extension instruction
- op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_i, rs2_i  in  XLEN  operands, sampled at acceptance
- rd_addr_i  in  RD_W  destination register
- flush_i  in  1  controller clean flag
- stall_i  in  1  controller EX hold flag, fed back
- multdiv_hold_flag_o  out  1  hold request to the controller
- result_o  out  XLEN  result
- result_valid_o  out  1  result/write enable for the EX output register
- rd_addr_o  out  RD_W  latched destination

## Operation
FSM states: IDLE, BUSY, DONE. Reset: state IDLE, counter 0, all outputs 0.

- **IDLE**
  - req_i & !flush_i: latch op, rd, operand magnitudes and result-sign flags; counter←0; go to BUSY.
  - multdiv_hold_flag_o = req_i & !flush_i, combinational in the acceptance cycle.
- **BUSY**
  - Hold = 1.
  - Each cycle performs one radix-2 step:
    - Multiply: shift-add into a 64-bit accumulator.
    - Divide: restoring shift-subtract, 32-bit remainder, quotient shifted in.
  - Counter 0..31; at counter 31 go to DONE.
- **DONE**
  - Hold = 0, result_valid_o = 1, result_o and rd_addr_o stable.
  - stall_i = 1: remain in DONE.
  - stall_i = 0: go to IDLE. req_i is ignored in DONE because the same instruction is still in EX.
- **Sign rules**
  - Signed operands are converted to magnitudes before iterating.
  - The result is negated at completion if the sign flag is set.
  - MULHSU: only rs1 is treated as signed.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- **Divide by zero**: quotient 0xFFFFFFFF, remainder = rs1, for both signed and unsigned.
- **Signed overflow** (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- Special-case results keep the full 33-cycle latency; no early exit.
- **Flush**: flush_i in any state has priority.
  - Hold = 0 and result_valid_o = 0 in that cycle.
  - State is IDLE next cycle, and the result is discarded.
- **Reset mid-operation**: state IDLE next cycle; no result is produced.

## Timing
- Cycle 0: acceptance; hold = 1.
- Cycles 1–32: BUSY; hold = 1.
- Cycle 33: DONE; hold = 0, valid = 1. The EX register captures the result at the end of cycle 33 unless stall_i is high.
- Hold is asserted for exactly 33 consecutive cycles when there is no flush.
- Valid is high for 1 + (number of stall cycles) cycles.
- The earliest back-to-back acceptance is cycle 34.
- result_o is registered; the only combinational paths are hold from req_i/flush_i and the state.

## Structure
- define.v holds:
  - funct3 op encodings
  - FSM state encodings
  - the iteration count constant (32)
  - the existing enable/disable macros
- One sub-module is natural: ysyx_23060072_multdiv_iter, the combinational single-step datapath (shift-add or shift-subtract selected by is_div). The top module keeps the FSM, counter, operand conditioning and sign fix-up.

## Test plan
- MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB; hold high cycles 0–32, valid only in cycle 33, rd_addr_o = rd_addr_i.
- Operand 0x80000000 × 0x80000000:
  - MULH → 0x40000000
  - MULHU → 0x40000000
  - MULHSU → 0xC0000000
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 7 / 2 → 3; REMU 7 / 2 → 1.
- DIV 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0. Latency is 33 cycles in every case.
- stall_i high for 3 cycles on reaching DONE, with req_i held high:
  - valid stays high for 4 cycles with the result stable
  - no restart occurs
  - state is IDLE after stall_i drops
- flush_i at BUSY cycle 10: hold 0 in that cycle, IDLE next, valid never asserts. Repeat with rst at cycle 10: same behavior.

Source files
------------

// File: rtl/ysyx_23060072_multdiv_pkg.sv
// Shared encodings for the iterative M-extension unit: funct3 ops, FSM states
// and the radix-2 iteration count.
package ysyx_23060072_multdiv_pkg;

  localparam int ITER_CNT = 32;
  localparam int CNT_W    = $clog2(ITER_CNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

endpackage

// File: rtl/ysyx_23060072_multdiv_iter.sv
// One combinational radix-2 step: shift-add for multiply, restoring
// shift-subtract for divide, both over a shared 2*XLEN accumulator.
module ysyx_23060072_multdiv_iter #(
  parameter int XLEN = 32
) (
  input  logic              isDiv_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   operand_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0]   addSum;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;

  // Multiply keeps {partial product, remaining multiplier}; divide keeps
  // {remainder, dividend bits shifting out / quotient bits shifting in}.
  always_comb begin
    addSum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    shifted = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, operand_i};
    if (isDiv_i) begin
      if (diff[XLEN+1]) begin
        acc_o = {shifted[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end else begin
        acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_o = {addSum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ysyx_23060072_multdiv.sv
// Iterative RV32 M-extension unit: accepts in IDLE, iterates 32 steps in BUSY,
// presents a registered result in DONE until the EX hold releases it.
module ysyx_23060072_multdiv
  import ysyx_23060072_multdiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [RD_W-1:0] rd_addr_i,
  input  logic            flush_i,
  input  logic            stall_i,
  output logic            multdiv_hold_flag_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o,
  output logic [RD_W-1:0] rd_addr_o
);

  state_e            state_q, state_d;
  op_e               op_q;
  logic [RD_W-1:0]   rd_q;
  logic [2*XLEN-1:0] acc_q, accNext;
  logic [XLEN-1:0]   operand_q;
  logic              resNeg_q, resNeg_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   result_q, finalResult;

  logic              accept, lastStep;
  logic              aSigned, bSigned, negA, negB, divZero;
  logic [XLEN-1:0]   magA, magB;
  logic [2*XLEN-1:0] mulProd;
  logic [XLEN-1:0]   quot, remd;

  assign accept   = (state_q == IDLE) && req_i && !flush_i;
  assign lastStep = (cnt_q == CNT_W'(ITER_CNT - 1));

  // Operand conditioning: iterate on magnitudes and remember the result sign.
  // A zero divisor forces a positive quotient so it reads back as all ones.
  always_comb begin
    aSigned  = (op_i != OP_MULHU) && (op_i != OP_DIVU) && (op_i != OP_REMU);
    bSigned  = aSigned && (op_i != OP_MULHSU);
    negA     = aSigned && rs1_i[XLEN-1];
    negB     = bSigned && rs2_i[XLEN-1];
    magA     = negA ? -rs1_i : rs1_i;
    magB     = negB ? -rs2_i : rs2_i;
    divZero  = (rs2_i == '0);
    resNeg_d = negA ^ negB;
    if (op_i == OP_DIV || op_i == OP_DIVU) begin
      resNeg_d = (negA ^ negB) && !divZero;
    end else if (op_i == OP_REM || op_i == OP_REMU) begin
      resNeg_d = negA;
    end
  end

  ysyx_23060072_multdiv_iter #(.XLEN(XLEN)) u_iter (
    .isDiv_i   (op_q[2]),
    .acc_i     (acc_q),
    .operand_i (operand_q),
    .acc_o     (accNext)
  );

  always_comb begin
    mulProd     = resNeg_q ? -accNext : accNext;
    quot        = resNeg_q ? -accNext[XLEN-1:0] : accNext[XLEN-1:0];
    remd        = resNeg_q ? -accNext[2*XLEN-1:XLEN] : accNext[2*XLEN-1:XLEN];
    finalResult = '0;
    case (op_q)
      OP_MUL:                        finalResult = mulProd[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  finalResult = mulProd[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               finalResult = quot;
      OP_REM, OP_REMU:               finalResult = remd;
      default:                       finalResult = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush wins in every state; DONE ignores req_i since the same instruction
  // is still sitting in EX.
  always_comb begin
    state_d             = state_q;
    multdiv_hold_flag_o = 1'b0;
    result_valid_o      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i && !flush_i) begin
          multdiv_hold_flag_o = 1'b1;
          state_d             = BUSY;
        end
      end
      BUSY: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          multdiv_hold_flag_o = 1'b1;
          if (lastStep) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          result_valid_o = 1'b1;
          if (!stall_i) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= OP_MUL;
      rd_q      <= '0;
      acc_q     <= '0;
      operand_q <= '0;
      resNeg_q  <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else if (accept) begin
      op_q      <= op_e'(op_i);
      rd_q      <= rd_addr_i;
      acc_q     <= {{XLEN{1'b0}}, magA};
      operand_q <= magB;
      resNeg_q  <= resNeg_d;
      cnt_q     <= '0;
    end else if (state_q == BUSY && !flush_i) begin
      acc_q <= accNext;
      cnt_q <= cnt_q + CNT_W'(1);
      if (lastStep) begin
        result_q <= finalResult;
      end
    end
  end

  assign result_o  = result_q;
  assign rd_addr_o = rd_q;

endmodule

// File: tb/tb_ysyx_23060072_multdiv.sv
// Self-checking bench: directed corner cases plus randomized ops compared
// against a plain-arithmetic reference of RV32M semantics.
module tb_ysyx_23060072_multdiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic [3:0]  rdAddr;
  logic        flush, stall;
  logic        hold;
  logic [31:0] result;
  logic        valid;
  logic [3:0]  rdOut;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  ysyx_23060072_multdiv #(.XLEN(32), .RD_W(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_i               (req),
    .op_i                (op),
    .rs1_i               (rs1),
    .rs2_i               (rs2),
    .rd_addr_i           (rdAddr),
    .flush_i             (flush),
    .stall_i             (stall),
    .multdiv_hold_flag_o (hold),
    .result_o            (result),
    .result_valid_o      (valid),
    .rd_addr_o           (rdOut)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // RV32M semantics straight from the ISA rules, using 64-bit arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0]        ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (fn)
      3'd0: begin sp = sa * sb; return sp[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sp = sa / sb;
        return sp[31:0];
      end
      3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        sp = sa % sb;
        return sp[31:0];
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: acceptance, 32 busy cycles, DONE (optionally stalled),
  // then one idle cycle. Inputs are scrambled after acceptance to prove latching.
  task automatic applyStimulus(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] rd, input int stallCycles, input string tag);
    logic [31:0] expected;
    int badHold;
    int badValid;
    expected = refModel(fn, a, b);
    badHold  = 0;
    badValid = 0;
    req = 1'b1; op = fn; rs1 = a; rs2 = b; rdAddr = rd; flush = 1'b0; stall = 1'b0;
    #1;
    checkOutput({tag, ".hold0"}, 64'(hold), 64'd1);
    if (valid) badValid++;
    nextCycle();
    op = 3'($urandom); rs1 = $urandom; rs2 = $urandom; rdAddr = 4'($urandom);
    for (int c = 1; c <= 32; c++) begin
      #1;
      if (!hold) badHold++;
      if (valid) badValid++;
      nextCycle();
    end
    checkOutput({tag, ".busyHold"}, 64'(badHold), 64'd0);
    checkOutput({tag, ".busyValid"}, 64'(badValid), 64'd0);
    stall = (stallCycles > 0);
    #1;
    checkOutput({tag, ".doneHold"}, 64'(hold), 64'd0);
    checkOutput({tag, ".doneValid"}, 64'(valid), 64'd1);
    checkOutput({tag, ".result"}, 64'(result), 64'(expected));
    checkOutput({tag, ".rd"}, 64'(rdOut), 64'(rd));
    for (int s = 1; s <= stallCycles; s++) begin
      nextCycle();
      stall = (s < stallCycles);
      #1;
      checkOutput({tag, ".stallValid"}, 64'(valid), 64'd1);
      checkOutput({tag, ".stallHold"}, 64'(hold), 64'd0);
      checkOutput({tag, ".stallResult"}, 64'(result), 64'(expected));
    end
    nextCycle();
    req = 1'b0; stall = 1'b0;
    #1;
    checkOutput({tag, ".idleHold"}, 64'(hold), 64'd0);
    checkOutput({tag, ".idleValid"}, 64'(valid), 64'd0);
  endtask

  // Abort at busy cycle 10 with either flush or reset; no result may appear.
  task automatic abortRun(input logic useReset, input string tag);
    int badValid;
    badValid = 0;
    req = 1'b1; op = 3'd4; rs1 = 32'd1000; rs2 = 32'd7; rdAddr = 4'd9; flush = 1'b0; stall = 1'b0;
    nextCycle();
    for (int c = 1; c < 10; c++) nextCycle();
    if (useReset) rst = 1'b1;
    else flush = 1'b1;
    #1;
    if (!useReset) checkOutput({tag, ".abortHold"}, 64'(hold), 64'd0);
    checkOutput({tag, ".abortValid"}, 64'(valid), 64'd0);
    nextCycle();
    rst = 1'b0; flush = 1'b0; req = 1'b0;
    #1;
    checkOutput({tag, ".idleHold"}, 64'(hold), 64'd0);
    for (int c = 0; c < 40; c++) begin
      if (valid) badValid++;
      nextCycle();
    end
    checkOutput({tag, ".neverValid"}, 64'(badValid), 64'd0);
  endtask

  initial begin
    logic [2:0]  fn;
    logic [31:0] a, b;
    int          sel;
    rst = 1'b1; req = 1'b0; op = 3'd0; rs1 = '0; rs2 = '0; rdAddr = '0; flush = 1'b0; stall = 1'b0;
    nextCycle();
    nextCycle();
    rst = 1'b0;
    #1;
    checkOutput("reset.hold", 64'(hold), 64'd0);
    checkOutput("reset.valid", 64'(valid), 64'd0);
    checkOutput("reset.result", 64'(result), 64'd0);
    checkOutput("reset.rd", 64'(rdOut), 64'd0);

    applyStimulus(3'd0, 32'd7,         32'hFFFF_FFFD, 4'd5,  0, "mulNeg");
    applyStimulus(3'd1, 32'h8000_0000, 32'h8000_0000, 4'd1,  0, "mulhMin");
    applyStimulus(3'd3, 32'h8000_0000, 32'h8000_0000, 4'd2,  0, "mulhuMin");
    applyStimulus(3'd2, 32'h8000_0000, 32'h8000_0000, 4'd3,  0, "mulhsuMin");
    applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4,  0, "mulhuMax");
    applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2,         4'd6,  0, "divNeg");
    applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2,         4'd7,  0, "remNeg");
    applyStimulus(3'd5, 32'd7,         32'd2,         4'd8,  0, "divu");
    applyStimulus(3'd7, 32'd7,         32'd2,         4'd9,  0, "remu");
    applyStimulus(3'd4, 32'd5,         32'd0,         4'd10, 0, "divZero");
    applyStimulus(3'd4, 32'hFFFF_FFFB, 32'd0,         4'd10, 0, "divZeroNeg");
    applyStimulus(3'd6, 32'hFFFF_FFFB, 32'd0,         4'd10, 0, "remZeroNeg");
    applyStimulus(3'd7, 32'd5,         32'd0,         4'd11, 0, "remuZero");
    applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'd12, 0, "divOvf");
    applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4'd13, 0, "remOvf");
    applyStimulus(3'd0, 32'd123,       32'd456,       4'd14, 3, "stall3");

    abortRun(1'b0, "flush");
    applyStimulus(3'd5, 32'd100, 32'd9, 4'd2, 0, "afterFlush");
    abortRun(1'b1, "reset");
    applyStimulus(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 4'd3, 0, "afterReset");

    for (int i = 0; i < 30; i++) begin
      fn  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'h0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      applyStimulus(fn, a, b, 4'($urandom), $urandom_range(0, 2), $sformatf("rand%0d.op%0d", i, fn));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
